// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the datapath (master) and the pipeline sequencing
// controller (slave): hazard/memory/halt status in, register enables and status out.
interface pipe_ctrl_if;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic [4:0]  ifid_rs1;
    logic [4:0]  ifid_rs2;
    logic        branch_taken;
    logic        exmem_memop;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_load;
    logic        ifid_load;
    logic        idex_load;
    logic        exmem_load;
    logic        memwb_load;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic        mem_err;
    logic [31:0] stall_cycles;

    modport master (
        output idex_memread, idex_rd, ifid_rs1, ifid_rs2,
               branch_taken, exmem_memop, mem_ready, halt_req,
        input  pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, halted, mem_err, stall_cycles
    );

    modport slave (
        input  idex_memread, idex_rd, ifid_rs1, ifid_rs2,
               branch_taken, exmem_memop, mem_ready, halt_req,
        output pc_load, ifid_load, idex_load, exmem_load, memwb_load,
               ifid_flush, idex_flush, halted, mem_err, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: load-use stalls, branch flushes, memory waits with timeout, halt.
// Optional stall-cycle performance counter is built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] waitCnt_q, waitCnt_d;
    logic       halted_q;
    logic       memErr_q;
    logic       setErr;
    logic       advance;
    logic       hazard;

    assign hazard = bus.idex_memread && (bus.idex_rd != 5'd0) &&
                    ((bus.idex_rd == bus.ifid_rs1) || (bus.idex_rd == bus.ifid_rs2));

    // Next state and the combinational enables; 'advance' selects the shared branch/hazard/normal rules.
    always_comb begin
        state_d        = state_q;
        waitCnt_d      = waitCnt_q;
        setErr         = 1'b0;
        advance        = 1'b0;
        bus.pc_load    = 1'b0;
        bus.ifid_load  = 1'b0;
        bus.idex_load  = 1'b0;
        bus.exmem_load = 1'b0;
        bus.memwb_load = 1'b0;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.exmem_memop && !bus.mem_ready) begin
                        state_d   = MEM_WAIT;
                        waitCnt_d = 8'd0;
                    end else begin
                        advance = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        if (bus.halt_req) begin
                            state_d = HALT;
                        end else begin
                            state_d = RUN;
                            advance = 1'b1;
                        end
                    end else if (waitCnt_q == WaitLast) begin
                        state_d = HALT;
                        setErr  = 1'b1;
                    end else begin
                        waitCnt_d = waitCnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = HALT;
                end
            endcase

            if (advance) begin
                if (bus.branch_taken) begin
                    bus.pc_load    = 1'b1;
                    bus.ifid_load  = 1'b1;
                    bus.idex_load  = 1'b1;
                    bus.exmem_load = 1'b1;
                    bus.memwb_load = 1'b1;
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end else if (hazard) begin
                    bus.idex_load  = 1'b1;
                    bus.idex_flush = 1'b1;
                    bus.exmem_load = 1'b1;
                    bus.memwb_load = 1'b1;
                end else begin
                    bus.pc_load    = 1'b1;
                    bus.ifid_load  = 1'b1;
                    bus.idex_load  = 1'b1;
                    bus.exmem_load = 1'b1;
                    bus.memwb_load = 1'b1;
                end
            end
        end
    end

    // Status flags are sticky until reset and become visible the cycle after the halt transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            waitCnt_q <= 8'd0;
            halted_q  <= 1'b0;
            memErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (state_d == HALT) begin
                halted_q <= 1'b1;
            end
            if (setErr) begin
                memErr_q <= 1'b1;
            end
        end
    end

    assign bus.halted  = halted_q;
    assign bus.mem_err = memErr_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= 32'd0;
        end else if (!bus.pc_load && (state_q != HALT)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign bus.stall_cycles = stallCnt_q;
`else
    assign bus.stall_cycles = 32'd0;
`endif

endmodule
